// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store responder on a req/ack data-memory bus
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] mem_data1_i,
    input  logic [15:0] mem_aluResult_i,
    input  logic [2:0]  mem_reg3_i,
    input  logic        mem_resultOrMem_i,
    input  logic        mem_memRead_i,
    input  logic        mem_memWrite_i,
    input  logic        mem_regWrite_i,
    input  logic [5:0]  stall_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [15:0] dm_addr_o,
    output logic [15:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [15:0] dm_rdata_i,
    output logic        stallreq_o,
    output logic [15:0] wb_data_o,
    output logic [2:0]  wb_reg3_o,
    output logic        wb_regWrite_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_rdata;
    logic               w_mem_op;
    logic               w_timeout;
    logic               w_unused_stall;

    assign w_mem_op       = mem_memRead_i | mem_memWrite_i;
    assign w_timeout      = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_unused_stall = ^{stall_i[5:4], stall_i[2:0]};

    always_comb begin
        w_next     = r_state;
        stallreq_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    w_next     = S_WAIT;
                    stallreq_o = 1'b1;
                end
            end
            S_WAIT: begin
                stallreq_o = 1'b1;
                if (dm_ack_i || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Holding here while MEM is stalled keeps the access from being re-issued.
                if (!stall_i[3]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rdata    <= 16'h0000;
            dm_req_o   <= 1'b0;
            dm_we_o    <= 1'b0;
            dm_addr_o  <= 16'h0000;
            dm_wdata_o <= 16'h0000;
            err_o      <= 1'b0;
        end else begin
            r_state <= w_next;
            err_o   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        dm_req_o   <= 1'b1;
                        dm_we_o    <= mem_memWrite_i;
                        dm_addr_o  <= mem_aluResult_i;
                        dm_wdata_o <= mem_data1_i;
                        r_cnt      <= '0;
                        // Read and write together is executed as a write and flagged.
                        err_o      <= mem_memRead_i & mem_memWrite_i;
                    end
                end
                S_WAIT: begin
                    if (dm_ack_i) begin
                        if (!dm_we_o) begin
                            r_rdata <= dm_rdata_i;
                        end
                        dm_req_o <= 1'b0;
                    end else if (w_timeout) begin
                        dm_req_o <= 1'b0;
                        r_rdata  <= 16'h0000;
                        err_o    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_data_o     = mem_resultOrMem_i ? r_rdata : mem_aluResult_i;
    assign wb_reg3_o     = mem_reg3_i;
    assign wb_regWrite_o = mem_regWrite_i & ~stallreq_o;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TO_T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data1, alu, rdata;
    logic [2:0]  reg3;
    logic        rom, rd, wr, rw, ack;
    logic [5:0]  stall;
    bit          sel_t;
    bit          probe;

    logic rd_m, wr_m, ack_m, rd_t, wr_t, ack_t;
    assign rd_m  = rd  & ~sel_t;
    assign wr_m  = wr  & ~sel_t;
    assign ack_m = ack & ~sel_t;
    assign rd_t  = rd  & sel_t;
    assign wr_t  = wr  & sel_t;
    assign ack_t = ack & sel_t;

    logic        m_req, m_we, m_stall, m_wbw, m_err;
    logic [15:0] m_addr, m_wdata, m_wb;
    logic [2:0]  m_reg3;
    logic        t_req, t_we, t_stall, t_wbw, t_err;
    logic [15:0] t_addr, t_wdata, t_wb;
    logic [2:0]  t_reg3;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst_n), .mem_data1_i(data1), .mem_aluResult_i(alu),
        .mem_reg3_i(reg3), .mem_resultOrMem_i(rom), .mem_memRead_i(rd_m),
        .mem_memWrite_i(wr_m), .mem_regWrite_i(rw), .stall_i(stall),
        .dm_req_o(m_req), .dm_we_o(m_we), .dm_addr_o(m_addr), .dm_wdata_o(m_wdata),
        .dm_ack_i(ack_m), .dm_rdata_i(rdata), .stallreq_o(m_stall), .wb_data_o(m_wb),
        .wb_reg3_o(m_reg3), .wb_regWrite_o(m_wbw), .err_o(m_err)
    );

    mem_access_unit #(.TIMEOUT(TO_T), .CNT_W(8)) dut_t (
        .clk_i(clk), .rst_i(rst_n), .mem_data1_i(data1), .mem_aluResult_i(alu),
        .mem_reg3_i(reg3), .mem_resultOrMem_i(rom), .mem_memRead_i(rd_t),
        .mem_memWrite_i(wr_t), .mem_regWrite_i(rw), .stall_i(stall),
        .dm_req_o(t_req), .dm_we_o(t_we), .dm_addr_o(t_addr), .dm_wdata_o(t_wdata),
        .dm_ack_i(ack_t), .dm_rdata_i(rdata), .stallreq_o(t_stall), .wb_data_o(t_wb),
        .wb_reg3_o(t_reg3), .wb_regWrite_o(t_wbw), .err_o(t_err)
    );

    typedef struct {
        bit          is_probe;
        bit          chk_bus;
        int          slen;
        int          rcyc;
        int          nreq;
        int          nerr;
        logic        stall;
        logic        req;
        logic        err;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] wb;
        logic        wbw;
        logic [2:0]  reg3;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: accumulates per-access statistics and compares at completion or probe points.
    int          c_slen = 0, c_rcyc = 0, c_nreq = 0, c_nerr = 0;
    bit          c_unstable = 0;
    logic        prev_req = 1'b0, prev_stall = 1'b0;
    logic [15:0] cap_addr = 16'h0, cap_wdata = 16'h0;
    logic        cap_we = 1'b0;

    always @(negedge clk) begin
        logic        s_req, s_we, s_stall, s_wbw, s_err;
        logic [15:0] s_addr, s_wdata, s_wb;
        logic [2:0]  s_reg3;
        exp_t        e;
        s_req   = sel_t ? t_req   : m_req;
        s_we    = sel_t ? t_we    : m_we;
        s_stall = sel_t ? t_stall : m_stall;
        s_wbw   = sel_t ? t_wbw   : m_wbw;
        s_err   = sel_t ? t_err   : m_err;
        s_addr  = sel_t ? t_addr  : m_addr;
        s_wdata = sel_t ? t_wdata : m_wdata;
        s_wb    = sel_t ? t_wb    : m_wb;
        s_reg3  = sel_t ? t_reg3  : m_reg3;
        if (rst_n) begin
            if (s_stall) c_slen++;
            if (s_req)   c_rcyc++;
            if (s_err)   c_nerr++;
            if (s_req && !prev_req) begin
                c_nreq++;
                cap_addr  = s_addr;
                cap_we    = s_we;
                cap_wdata = s_wdata;
            end else if (s_req && (s_addr !== cap_addr || s_we !== cap_we || s_wdata !== cap_wdata)) begin
                c_unstable = 1'b1;
            end
        end
        if (probe || (rst_n && prev_stall && !s_stall)) begin
            if (q.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                chk("record_kind", {31'd0, probe}, {31'd0, e.is_probe});
                if (e.is_probe) begin
                    chk("probe_stallreq", {31'd0, s_stall}, {31'd0, e.stall});
                    chk("probe_req", {31'd0, s_req}, {31'd0, e.req});
                    chk("probe_err", {31'd0, s_err}, {31'd0, e.err});
                    chk("probe_nreq", c_nreq, e.nreq);
                    chk("probe_nerr", c_nerr, e.nerr);
                    if (e.chk_bus) begin
                        chk("probe_addr", {16'd0, s_addr}, {16'd0, e.addr});
                        chk("probe_we", {31'd0, s_we}, {31'd0, e.we});
                        chk("probe_wdata", {16'd0, s_wdata}, {16'd0, e.wdata});
                    end
                end else begin
                    chk("acc_stall_len", c_slen, e.slen);
                    chk("acc_req_cycles", c_rcyc, e.rcyc);
                    chk("acc_nreq", c_nreq, e.nreq);
                    chk("acc_nerr", c_nerr, e.nerr);
                    chk("acc_addr", {16'd0, cap_addr}, {16'd0, e.addr});
                    chk("acc_we", {31'd0, cap_we}, {31'd0, e.we});
                    chk("acc_wdata", {16'd0, cap_wdata}, {16'd0, e.wdata});
                    chk("acc_bus_stable", {31'd0, c_unstable}, 32'd0);
                end
                chk("wb_data", {16'd0, s_wb}, {16'd0, e.wb});
                chk("wb_regwrite", {31'd0, s_wbw}, {31'd0, e.wbw});
                chk("wb_reg3", {29'd0, s_reg3}, {29'd0, e.reg3});
            end
            c_slen = 0; c_rcyc = 0; c_nreq = 0; c_nerr = 0; c_unstable = 1'b0;
        end
        if (!rst_n) begin
            c_slen = 0; c_rcyc = 0; c_nreq = 0; c_nerr = 0; c_unstable = 1'b0;
            prev_req   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            prev_req   = s_req;
            prev_stall = s_stall;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk_acc(input int slen, input int rcyc, input int nerr,
                                    input logic [15:0] a, input logic we, input logic [15:0] wd,
                                    input logic [15:0] wb, input logic wbw, input logic [2:0] rg);
        exp_t e;
        e = '{is_probe: 1'b0, chk_bus: 1'b0, slen: slen, rcyc: rcyc, nreq: 1, nerr: nerr,
              stall: 1'b0, req: 1'b0, err: 1'b0, addr: a, we: we, wdata: wd,
              wb: wb, wbw: wbw, reg3: rg};
        return e;
    endfunction

    function automatic exp_t mk_probe(input logic [15:0] wb, input logic wbw, input logic [2:0] rg,
                                      input bit cb, input logic [15:0] a, input logic we,
                                      input logic [15:0] wd);
        exp_t e;
        e = '{is_probe: 1'b1, chk_bus: cb, slen: 0, rcyc: 0, nreq: 0, nerr: 0,
              stall: 1'b0, req: 1'b0, err: 1'b0, addr: a, we: we, wdata: wd,
              wb: wb, wbw: wbw, reg3: rg};
        return e;
    endfunction

    task automatic do_probe(input exp_t e);
        q.push_back(e);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
        tick();
    endtask

    // delay < 0 means no ack (timeout instance); hold = DONE cycles with stall_i[3] set.
    task automatic do_access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                             input logic ro, input logic rwv, input logic [2:0] rg,
                             input int delay, input logic [15:0] rdv, input int hold, input exp_t e);
        q.push_back(e);
        rd = r; wr = w; alu = a; data1 = d; rom = ro; rw = rwv; reg3 = rg;
        tick();
        if (delay >= 0) begin
            repeat (delay) tick();
            ack = 1'b1;
            rdata = rdv;
            tick();
            ack = 1'b0;
            rdata = 16'hDEAD;
        end else begin
            repeat (TO_T) tick();
        end
        if (hold > 0) begin
            stall[3] = 1'b1;
            repeat (hold) tick();
            stall[3] = 1'b0;
        end
        tick();
        rd = 1'b0; wr = 1'b0; rom = 1'b0; rw = 1'b0; reg3 = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0; data1 = 16'h0; alu = 16'h0; rdata = 16'h0; reg3 = 3'd0;
        rom = 1'b0; rd = 1'b0; wr = 1'b0; rw = 1'b0; ack = 1'b0; stall = 6'd0;
        sel_t = 1'b0; probe = 1'b0;
        repeat (2) tick();
        rom = 1'b1;
        do_probe(mk_probe(16'h0000, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b0, 16'h0000));
        rst_n = 1'b1;
        tick();

        rom = 1'b0; rw = 1'b1; alu = 16'h1234; reg3 = 3'd5;
        do_probe(mk_probe(16'h1234, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0, 16'h0));
        do_probe(mk_probe(16'h1234, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0, 16'h0));
        rw = 1'b0; reg3 = 3'd0;

        do_access(1'b1, 1'b0, 16'h0040, 16'h7777, 1'b1, 1'b1, 3'd2, 0, 16'hBEEF, 0,
                  mk_acc(2, 1, 0, 16'h0040, 1'b0, 16'h7777, 16'hBEEF, 1'b1, 3'd2));
        do_access(1'b0, 1'b1, 16'h0010, 16'h00A5, 1'b0, 1'b0, 3'd0, 5, 16'h0000, 0,
                  mk_acc(7, 6, 0, 16'h0010, 1'b1, 16'h00A5, 16'h0010, 1'b0, 3'd0));

        rom = 1'b1; rw = 1'b1; alu = 16'h9999; reg3 = 3'd7;
        do_probe(mk_probe(16'hBEEF, 1'b1, 3'd7, 1'b1, 16'h0010, 1'b1, 16'h00A5));

        do_access(1'b1, 1'b1, 16'h0022, 16'h1111, 1'b0, 1'b0, 3'd1, 0, 16'h0000, 0,
                  mk_acc(2, 1, 1, 16'h0022, 1'b1, 16'h1111, 16'h0022, 1'b0, 3'd1));

        do_access(1'b1, 1'b0, 16'h0044, 16'h0000, 1'b1, 1'b1, 3'd4, 0, 16'h1357, 3,
                  mk_acc(2, 1, 0, 16'h0044, 1'b0, 16'h0000, 16'h1357, 1'b1, 3'd4));
        rom = 1'b1;
        do_probe(mk_probe(16'h1357, 1'b0, 3'd0, 1'b1, 16'h0044, 1'b0, 16'h0000));

        sel_t = 1'b1;
        do_access(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1, 1'b1, 3'd3, 2, 16'h5A5A, 0,
                  mk_acc(4, 3, 0, 16'h0050, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 3'd3));
        do_access(1'b1, 1'b0, 16'h0080, 16'h0000, 1'b1, 1'b1, 3'd6, -1, 16'h0000, 0,
                  mk_acc(5, 4, 1, 16'h0080, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd6));
        ack = 1'b1; rdata = 16'hFFFF;
        tick();
        ack = 1'b0;
        rom = 1'b1; rw = 1'b1; reg3 = 3'd6;
        do_probe(mk_probe(16'h0000, 1'b1, 3'd6, 1'b1, 16'h0080, 1'b0, 16'h0000));
        rom = 1'b0; rw = 1'b0; reg3 = 3'd0;
        tick();
        sel_t = 1'b0;

        rd = 1'b1; alu = 16'h0030; data1 = 16'h4444; rw = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        rd = 1'b0;
        do_probe(mk_probe(16'h0030, 1'b1, 3'd0, 1'b1, 16'h0000, 1'b0, 16'h0000));
        rst_n = 1'b1;
        rw = 1'b0;
        tick();
        ack = 1'b1; rdata = 16'hCCCC;
        tick();
        ack = 1'b0;
        rom = 1'b1;
        do_probe(mk_probe(16'h0000, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b0, 16'h0000));
        rom = 1'b0;

        do_access(1'b1, 1'b0, 16'h0060, 16'h0000, 1'b1, 1'b1, 3'd5, 1, 16'h0F0F, 0,
                  mk_acc(3, 2, 0, 16'h0060, 1'b0, 16'h0000, 16'h0F0F, 1'b1, 3'd5));

        repeat (3) tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
